// File: rtl/timer_prescaled_if.sv
// Control/status bundle between the control FSM and timer_prescaled.
// Compare port pair exists only under TIMER_PRESCALED_CMP_EN.
interface timer_prescaled_if #(
  parameter int CNT_W = 4
);
  logic [1:0]       ctrl;
  logic             mode;
  logic             autoreload;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] tmout;
  logic             tick;
  logic             expired;
  logic             done;
`ifdef TIMER_PRESCALED_CMP_EN
  logic [CNT_W-1:0] cmp_val;
  logic             match;

  modport master (
    output ctrl, mode, autoreload,
    output load_val, cmp_val,
    input  tmout, tick, expired,
    input  done, match
  );

  modport slave (
    input  ctrl, mode, autoreload,
    input  load_val, cmp_val,
    output tmout, tick, expired,
    output done, match
  );
`else
  modport master (
    output ctrl, mode, autoreload,
    output load_val,
    input  tmout, tick, expired,
    input  done
  );

  modport slave (
    input  ctrl, mode, autoreload,
    input  load_val,
    output tmout, tick, expired,
    output done
  );
`endif
endinterface

// File: rtl/timer_prescaled.sv
// Prescaled up/down event timer with preload and one-shot/auto-reload.
// Optional compare output enabled by TIMER_PRESCALED_CMP_EN.
module timer_prescaled #(
  parameter int PRESCALE = 12,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  timer_prescaled_if.slave bus
);

  localparam int PS_W =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST =
    PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] ONES = '1;

  logic [PS_W-1:0]  ps, ps_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] rld, rld_n;
  logic             tick_q, tick_n;
  logic             exp_q, exp_n;
  logic             done_q, done_n;

  logic is_hold, is_clr, is_run, is_ld;
  logic step;
  logic at_term;

  assign is_hold = (bus.ctrl == 2'b00);
  assign is_clr  = (bus.ctrl == 2'b01);
  assign is_run  = (bus.ctrl == 2'b10);
  assign is_ld   = (bus.ctrl == 2'b11);

  assign at_term = bus.mode ? (cnt == '0)
                            : (cnt == ONES);

  always_comb begin
    ps_n   = ps;
    cnt_n  = cnt;
    rld_n  = rld;
    done_n = done_q;
    tick_n = 1'b0;
    exp_n  = 1'b0;
    step   = 1'b0;
    unique case (1'b1)
      is_hold: begin
      end
      is_clr: begin
        ps_n   = '0;
        cnt_n  = '0;
        done_n = 1'b0;
      end
      is_ld: begin
        ps_n   = '0;
        cnt_n  = bus.load_val;
        rld_n  = bus.load_val;
        done_n = 1'b0;
      end
      is_run: begin
        if (!done_q) begin
          if (ps == PS_LAST) begin
            ps_n = '0;
            step = 1'b1;
          end else begin
            ps_n = ps + PS_W'(1);
          end
        end
      end
      default: begin
      end
    endcase
    if (step) begin
      tick_n = 1'b1;
      if (!at_term) begin
        cnt_n = bus.mode ? cnt - CNT_W'(1)
                         : cnt + CNT_W'(1);
      end else begin
        exp_n = 1'b1;
        if (bus.autoreload)
          cnt_n = bus.mode ? rld : '0;
        else
          done_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps     <= '0;
      cnt    <= '0;
      rld    <= '0;
      tick_q <= 1'b0;
      exp_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ps     <= ps_n;
      cnt    <= cnt_n;
      rld    <= rld_n;
      tick_q <= tick_n;
      exp_q  <= exp_n;
      done_q <= done_n;
    end
  end

  assign bus.tmout   = cnt;
  assign bus.tick    = tick_q;
  assign bus.expired = exp_q;
  assign bus.done    = done_q;

`ifdef TIMER_PRESCALED_CMP_EN
  // Compare against next count so match lines up with tmout.
  logic match_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      match_q <= 1'b0;
    else
      match_q <= (cnt_n == bus.cmp_val);
  end

  assign bus.match = match_q;
`endif

endmodule
